// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_pkg
// Purpose  : Shared op encoding and default sizing for the regfile stack.
// Revision : 1.0
// ============================================================================
package stack_pkg;

    // Encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_t;

    localparam int STACK_DEPTH = 32;
    localparam int STACK_WIDTH = 32;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem
// Purpose  : DEPTH x WIDTH register file, one sync write, two async reads.
// Revision : 1.0
// ============================================================================
module stack_mem #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1
);

    // Storage is deliberately unreset; the top masks stale entries by count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];

endmodule : stack_mem
`default_nettype wire

// File: rtl/regfile_stack.sv
`default_nettype none
// ============================================================================
// Module   : regfile_stack
// Purpose  : LIFO over a register file with top-two read-out and sticky errors.
// Revision : 1.0
// ============================================================================
module regfile_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] stack_top,
    output logic [WIDTH-1:0] stack_top_minus_one,
    output logic [PTR_W-1:0] stack_ptr,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int               c_ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_DEPTH_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_ONE       = PTR_W'(1);
    localparam logic [PTR_W-1:0] c_TWO       = PTR_W'(2);

    logic [PTR_W-1:0]    r_ptr;
    logic                r_overflow;
    logic                r_underflow;

    stack_op_t           w_op;
    logic                w_full;
    logic                w_empty;
    logic                w_we;
    logic [c_ADDR_W-1:0] w_waddr;
    logic [c_ADDR_W-1:0] w_top_addr;
    logic [c_ADDR_W-1:0] w_nxt_addr;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic [WIDTH-1:0]    w_rd_top;
    logic [WIDTH-1:0]    w_rd_second;

    assign w_op       = stack_op_t'({push, pop});
    assign w_full     = (r_ptr == c_DEPTH_PTR);
    assign w_empty    = (r_ptr == '0);
    assign w_top_addr = c_ADDR_W'(r_ptr - c_ONE);
    assign w_nxt_addr = c_ADDR_W'(r_ptr - c_TWO);

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = c_ADDR_W'(r_ptr);
        w_ptr_nxt = r_ptr;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we      = 1'b1;
                    w_ptr_nxt = r_ptr + c_ONE;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr - c_ONE;
                end
            end
            OP_REPLACE: begin
                // Replace on an empty stack degenerates to a push into slot 0.
                w_we = 1'b1;
                if (w_empty) begin
                    w_ptr_nxt = r_ptr + c_ONE;
                end else begin
                    w_waddr = w_top_addr;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    stack_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (c_ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (data_in),
        .raddr0 (w_top_addr),
        .rdata0 (w_rd_top),
        .raddr1 (w_nxt_addr),
        .rdata1 (w_rd_second)
    );

    assign stack_top           = (r_ptr >= c_ONE) ? w_rd_top    : '0;
    assign stack_top_minus_one = (r_ptr >= c_TWO) ? w_rd_second : '0;
    assign stack_ptr           = r_ptr;
    assign full                = w_full;
    assign empty               = w_empty;
    assign overflow            = r_overflow;
    assign underflow           = r_underflow;

endmodule : regfile_stack
`default_nettype wire

// File: tb/tb_regfile_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_stack
// Purpose  : Directed and random checks of regfile_stack against a queue model.
// Revision : 1.0
// ============================================================================
module tb_regfile_stack;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int PTR_W = 6;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             err_clr;
    logic [WIDTH-1:0] stack_top;
    logic [WIDTH-1:0] stack_top_minus_one;
    logic [PTR_W-1:0] stack_ptr;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    regfile_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .push                (push),
        .pop                 (pop),
        .data_in             (data_in),
        .err_clr             (err_clr),
        .stack_top           (stack_top),
        .stack_top_minus_one (stack_top_minus_one),
        .stack_ptr           (stack_ptr),
        .full                (full),
        .empty               (empty),
        .overflow            (overflow),
        .underflow           (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    logic             m_unf;
    int               n_cmp;
    int               n_err;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int               n;
        logic [WIDTH-1:0] e_top;
        logic [WIDTH-1:0] e_sec;
        n     = m_q.size();
        e_top = (n >= 1) ? m_q[n-1] : '0;
        e_sec = (n >= 2) ? m_q[n-2] : '0;
        check({tag, ".top"},   stack_top,              e_top);
        check({tag, ".top1"},  stack_top_minus_one,    e_sec);
        check({tag, ".ptr"},   WIDTH'(stack_ptr),      WIDTH'(n));
        check({tag, ".full"},  WIDTH'(full),           WIDTH'(n == DEPTH));
        check({tag, ".empty"}, WIDTH'(empty),          WIDTH'(n == 0));
        check({tag, ".ovf"},   WIDTH'(overflow),       WIDTH'(m_ovf));
        check({tag, ".unf"},   WIDTH'(underflow),      WIDTH'(m_unf));
    endtask

    task automatic model_step(input logic p, input logic o,
                              input logic [WIDTH-1:0] d, input logic c);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (p && !o) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else                    m_ovf = 1'b1;
        end else if (!p && o) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else                m_unf = 1'b1;
        end else if (p && o) begin
            if (m_q.size() == 0) m_q.push_back(d);
            else                 m_q[m_q.size()-1] = d;
        end
    endtask

    task automatic do_op(input string tag, input logic p, input logic o,
                         input logic [WIDTH-1:0] d, input logic c);
        @(negedge clk);
        push    = p;
        pop     = o;
        data_in = d;
        err_clr = c;
        @(posedge clk);
        model_step(p, o, d, c);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int r;
        n_cmp   = 0;
        n_err   = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        err_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two pushes, then pops down past empty
        do_op("push3", 1'b1, 1'b0, 32'h3, 1'b0);
        do_op("push4", 1'b1, 1'b0, 32'h4, 1'b0);
        check("push4.top_const", stack_top, 32'h4);
        check("push4.top1_const", stack_top_minus_one, 32'h3);
        do_op("pop1", 1'b0, 1'b1, 32'h0, 1'b0);
        check("pop1.top_const", stack_top, 32'h3);
        do_op("pop2", 1'b0, 1'b1, 32'h0, 1'b0);
        do_op("pop3", 1'b0, 1'b1, 32'h0, 1'b0);
        check("pop3.unf_const", WIDTH'(underflow), 32'h1);

        // Underflow with simultaneous clear: set wins, then clear alone
        do_op("clr_pop", 1'b0, 1'b1, 32'h0, 1'b1);
        do_op("clr_only", 1'b0, 1'b0, 32'h0, 1'b1);
        check("clr_only.unf_const", WIDTH'(underflow), 32'h0);

        // Replace on empty acts as a push
        do_op("rep_empty", 1'b1, 1'b1, 32'h7, 1'b0);
        check("rep_empty.top_const", stack_top, 32'h7);
        do_op("pop_7", 1'b0, 1'b1, 32'h0, 1'b0);

        // Fill to capacity, then one refused push
        for (int i = 1; i <= DEPTH; i++) begin
            do_op("fill", 1'b1, 1'b0, WIDTH'(i), 1'b0);
        end
        do_op("push_full", 1'b1, 1'b0, 32'hDEAD, 1'b0);
        check("push_full.top_const", stack_top, 32'd32);
        check("push_full.ovf_const", WIDTH'(overflow), 32'h1);
        do_op("rep_full", 1'b1, 1'b1, 32'hBEEF, 1'b0);
        do_op("pop_full", 1'b0, 1'b1, 32'h0, 1'b1);
        check("pop_full.top_const", stack_top, 32'd31);

        // Drain, then replace on [5,9]
        while (m_q.size() > 0) do_op("drain", 1'b0, 1'b1, 32'h0, 1'b0);
        do_op("push5", 1'b1, 1'b0, 32'h5, 1'b0);
        do_op("push9", 1'b1, 1'b0, 32'h9, 1'b0);
        do_op("rep_e", 1'b1, 1'b1, 32'hE, 1'b0);
        check("rep_e.top_const", stack_top, 32'hE);
        check("rep_e.top1_const", stack_top_minus_one, 32'h5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            do_op("rand", (r < 55), (r >= 40 && r < 85), $urandom,
                  ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset between edges, then a push held over release
        while (m_q.size() > 0) do_op("drain2", 1'b0, 1'b1, 32'h0, 1'b0);
        do_op("pre_rst_a", 1'b1, 1'b0, 32'h11, 1'b0);
        do_op("pre_rst_b", 1'b1, 1'b0, 32'h22, 1'b0);
        do_op("pre_rst_c", 1'b1, 1'b0, 32'h33, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_all("async_rst");
        push    = 1'b1;
        data_in = 32'h44;
        @(posedge clk);
        rst <= 1'b0;
        #1;
        push = 1'b0;
        check_all("rst_release");
        do_op("post_rst", 1'b1, 1'b0, 32'h55, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_stack
`default_nettype wire

// File: doc/regfile_stack.md
# regfile_stack

LIFO stack that sits beneath the RPN calculator and responds to its one-cycle `push`/`pop` strobes. It is built on a register-file memory with synchronous write and asynchronous read. It presents the top two entries combinationally for the HEX displays and ALU, and the entry count for the LEDG counter. Illegal requests are absorbed without corrupting state and are reported through sticky error flags.

## Interface
- `DEPTH`, default 32: number of entries; must be ≤ 2**`PTR_W` − 1.
- `WIDTH`, default 32: entry width in bits.
- `PTR_W`, default 6: width of `stack_ptr`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `push`  in  1  push `data_in` this cycle (level sampled each edge).
- `pop`  in  1  discard top entry this cycle.
- `data_in`  in  WIDTH  value to push or replace with.
- `err_clr`  in  1  synchronous clear of sticky error flags.
- `stack_top`  out  WIDTH  entry at index `stack_ptr`−1; 0 when empty.
- `stack_top_minus_one`  out  WIDTH  entry at index `stack_ptr`−2; 0 when fewer than 2 entries.
- `stack_ptr`  out  PTR_W  current entry count, 0..DEPTH.
- `full`  out  1  `stack_ptr` == DEPTH.
- `empty`  out  1  `stack_ptr` == 0.
- `overflow`  out  1  sticky: a push was refused because the stack was full.
- `underflow`  out  1  sticky: a pop was refused because the stack was empty.

## Operation
- Each edge, `{push,pop}` decodes to one of four operations:
  - NONE (00): no state change.
  - PUSH (10):
    - Not full: `mem[ptr]` ← `data_in`; `ptr` ← `ptr`+1.
    - Full: no change; `overflow` ← 1.
  - POP (01):
    - Not empty: `ptr` ← `ptr`−1. The popped entry is not cleared; a later push overwrites it.
    - Empty: no change; `underflow` ← 1.
  - REPLACE (11):
    - Not empty: `mem[ptr−1]` ← `data_in`; `ptr` unchanged. This is legal when full and sets no flag.
    - Empty: behaves as PUSH (`ptr` 0→1); no `underflow`.
- `err_clr` clears `overflow` and `underflow`. If a new error occurs in the same cycle, the flag is set (set wins over clear).
- Read outputs are purely combinational from `ptr` and memory. They are masked to 0 by count, so stale popped data is never visible.
- `full`, `empty` and `stack_ptr` are combinational decodes of the `ptr` register.
- `data_in` is stored verbatim at WIDTH bits. No arithmetic is done on data.
- `ptr` never wraps: it saturates at 0 and DEPTH through the refusal rules above.

## Timing
- Write latency is 1 cycle. The pushed or replaced value appears on `stack_top` immediately after the capturing edge. The previous top moves to `stack_top_minus_one` in the same cycle.
- A pop is visible on `stack_top` and `stack_top_minus_one` right after its edge.
- Back-to-back operations on consecutive edges are fully supported; there is no busy state and no handshake beyond the strobe.
- The calculator's pop1→pop2→push1 sequence therefore completes in 3 edges. The result is visible on `stack_top` after the third edge.
- Reset values:
  - `ptr` = 0, so `stack_ptr` = 0, `empty` = 1, `full` = 0.
  - `stack_top` = 0 and `stack_top_minus_one` = 0.
  - `overflow` = `underflow` = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation clears state asynchronously. A strobe coincident with the reset release edge is ignored.
- Error flags rise on the edge that refuses the operation and stay high until `err_clr` or reset.

## Structure
- Package `stack_pkg` holds:
  - `typedef enum logic [1:0] {OP_NONE, OP_POP, OP_PUSH, OP_REPLACE} stack_op_t`, encoded as `{push,pop}`.
  - Default constants `STACK_DEPTH` = 32 and `STACK_WIDTH` = 32.
- Sub-module `stack_mem`:
  - DEPTH×WIDTH register file.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - Two asynchronous read ports.
  - No reset on storage.
- Top level holds the op decode, the `ptr` register, the error flags and the output masking.

## Test plan
- Reset, then push 0x0003 and push 0x0004 on consecutive edges -> `stack_top`=4, `stack_top_minus_one`=3, `stack_ptr`=2, `empty`=0.
- From the state above, pop, then pop, then pop -> `ptr` goes 1 then 0 with `stack_top` 3 then 0; the third pop sets `underflow`=1 and `ptr` stays 0.
- Push 32 distinct values 1..32, then a 33rd push of 0xDEAD -> `full`=1, `stack_ptr`=32, `stack_top`=32, `overflow`=1. Then pop -> `stack_top`=31, `full`=0.
- With stack [5,9] (top 9), assert push+pop with `data_in`=0x0E -> `stack_top`=0x0E, `stack_top_minus_one`=5, `ptr`=2. On an empty stack, push+pop with 7 -> `ptr`=1, `stack_top`=7, no flag.
- Set `underflow`, then assert `err_clr` with a simultaneous empty pop -> `underflow` stays 1. A following `err_clr` alone -> `underflow`=0.
- Push 3 values, then assert `rst` asynchronously between edges -> `stack_ptr`=0 and outputs 0 before the next edge. A push strobe held over the reset release edge -> `ptr` remains 0.
